// File: rtl/tcam_search_pipe.sv
// Ternary CAM: DEPTH value/care-mask entries searched in parallel, lowest matching index wins.
// Latency: key sampled at edge N, match lines registered at N, result registered at N+1.
// Backpressure: none; one search accepted every cycle, results stream out in order.
module tcam_search_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [WIDTH-1:0] wr_mask,
   input  logic             wr_valid,
   input  logic             srch_en,
   input  logic [WIDTH-1:0] srch_key,
   output logic             rslt_valid,
   output logic             rslt_hit,
   output logic [IDX_W-1:0] rslt_idx,
   output logic             rslt_multi
);

   // Entry storage. Value and mask carry no reset; only the valid bits do.
   logic [WIDTH-1:0] ent_val [DEPTH];
   logic [WIDTH-1:0] ent_msk [DEPTH];
   logic [DEPTH-1:0] ent_vld;

   // Per-entry write decode; an address that matches no entry slot is simply dropped.
   logic [DEPTH-1:0] wr_sel;

   // Combinational match lines against current (pre-write) contents.
   logic [DEPTH-1:0] match_lines;

   // Stage-1 registers: frozen match lines plus stage valid.
   logic             s1_vld;
   logic [DEPTH-1:0] s1_lines;

   // Priority encode results computed from stage-1 lines.
   logic             enc_hit;
   logic [IDX_W-1:0] enc_idx;
   logic             enc_multi;

   // Decode the write address into a one-hot select, bounded to real entries.
   always_comb begin
      wr_sel = '0;
      for (int e = 0; e < DEPTH; e++) begin
         if (wr_en && (wr_addr == IDX_W'(e))) begin
            wr_sel[e] = 1'b1;
         end
      end
   end

   // Load value and mask of the addressed entry.
   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         if (wr_sel[e]) begin
            ent_val[e] <= wr_data;
            ent_msk[e] <= wr_mask;
         end
      end
   end

   // Valid bits: clear wipes everything, then a same-edge write installs its own valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_vld <= '0;
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (wr_sel[e]) begin
               ent_vld[e] <= wr_valid;
            end else if (clr) begin
               ent_vld[e] <= 1'b0;
            end
         end
      end
   end

   // Ternary compare: a bit matches when its care bit is 0 or value equals key.
   always_comb begin
      match_lines = '0;
      for (int e = 0; e < DEPTH; e++) begin
         match_lines[e] = ent_vld[e] && (((ent_val[e] ^ srch_key) & ent_msk[e]) == '0);
      end
   end

   // Stage 1: capture match lines so later writes/clears cannot disturb this search.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld   <= 1'b0;
         s1_lines <= '0;
      end else begin
         s1_vld <= srch_en;
         if (srch_en) begin
            s1_lines <= match_lines;
         end
      end
   end

   // Lowest-index priority encode with a second-match detector for the multi flag.
   always_comb begin
      enc_hit   = 1'b0;
      enc_idx   = '0;
      enc_multi = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
         if (s1_lines[e]) begin
            if (enc_hit) begin
               enc_multi = 1'b1;
            end else begin
               enc_idx = IDX_W'(e);
            end
            enc_hit = 1'b1;
         end
      end
   end

   // Stage 2: registered result; payload held at zero whenever the strobe is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rslt_valid <= 1'b0;
         rslt_hit   <= 1'b0;
         rslt_idx   <= '0;
         rslt_multi <= 1'b0;
      end else begin
         rslt_valid <= s1_vld;
         rslt_hit   <= s1_vld & enc_hit;
         rslt_idx   <= s1_vld ? enc_idx : '0;
         rslt_multi <= s1_vld & enc_multi;
      end
   end

endmodule

// File: tb/tb_tcam_search_pipe.sv
// Directed bench for tcam_search_pipe: table of writes/searches plus hand-written pipeline cases.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Every comparison steps total; mismatches step bad and print a FAIL line.
module tb_tcam_search_pipe;

   logic       clk;
   logic       rst_n;
   logic       clr;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] wr_mask;
   logic       wr_valid;
   logic       srch_en;
   logic [7:0] srch_key;
   logic       rslt_valid;
   logic       rslt_hit;
   logic [3:0] rslt_idx;
   logic       rslt_multi;

   int total = 0;
   int bad   = 0;

   tcam_search_pipe #(.WIDTH(8), .DEPTH(16), .IDX_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_mask    (wr_mask),
      .wr_valid   (wr_valid),
      .srch_en    (srch_en),
      .srch_key   (srch_key),
      .rslt_valid (rslt_valid),
      .rslt_hit   (rslt_hit),
      .rslt_idx   (rslt_idx),
      .rslt_multi (rslt_multi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         is_srch;
      logic [3:0] addr;
      logic [7:0] data;
      logic [7:0] mask;
      bit         vld;
      logic [7:0] key;
      bit         exp_hit;
      logic [3:0] exp_idx;
      bit         exp_multi;
   } vec_t;

   vec_t tbl [11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_rslt(input string name, input bit v, input bit h, input int idx, input bit m);
      check({name, ".valid"}, int'(rslt_valid), int'(v));
      check({name, ".hit"},   int'(rslt_hit),   int'(h));
      check({name, ".idx"},   int'(rslt_idx),   idx);
      check({name, ".multi"}, int'(rslt_multi), int'(m));
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic [7:0] mk, input bit v);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = mk; wr_valid = v;
      tick();
      wr_en = 1'b0;
   endtask

   // Isolated search: nothing visible one edge after sampling, result after the second.
   task automatic do_search(input string name, input logic [7:0] k, input bit h, input int idx, input bit m);
      srch_en = 1'b1; srch_key = k;
      tick();
      srch_en = 1'b0;
      check({name, ".lat1"}, int'(rslt_valid), 0);
      tick();
      check_rslt(name, 1'b1, h, idx, m);
   endtask

   logic [7:0] bb_key [4];
   bit         bb_hit [4];
   int         bb_idx [4];

   initial begin
      rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      wr_mask = '0; wr_valid = 1'b0; srch_en = 1'b0; srch_key = '0;

      //                is_srch addr   data    mask    vld   key    hit   idx    multi
      tbl[0]  = '{1'b1, 4'd0,  8'h00, 8'h00, 1'b0, 8'hA5, 1'b0, 4'd0,  1'b0};
      tbl[1]  = '{1'b0, 4'd3,  8'hA0, 8'hF0, 1'b1, 8'h00, 1'b0, 4'd0,  1'b0};
      tbl[2]  = '{1'b1, 4'd0,  8'h00, 8'h00, 1'b0, 8'hA7, 1'b1, 4'd3,  1'b0};
      tbl[3]  = '{1'b1, 4'd0,  8'h00, 8'h00, 1'b0, 8'hB7, 1'b0, 4'd0,  1'b0};
      tbl[4]  = '{1'b0, 4'd9,  8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 4'd0,  1'b0};
      tbl[5]  = '{1'b1, 4'd0,  8'h00, 8'h00, 1'b0, 8'hA7, 1'b1, 4'd3,  1'b1};
      tbl[6]  = '{1'b1, 4'd0,  8'h00, 8'h00, 1'b0, 8'h12, 1'b1, 4'd9,  1'b0};
      tbl[7]  = '{1'b0, 4'd9,  8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 4'd0,  1'b0};
      tbl[8]  = '{1'b1, 4'd0,  8'h00, 8'h00, 1'b0, 8'h12, 1'b0, 4'd0,  1'b0};
      tbl[9]  = '{1'b0, 4'd15, 8'h5A, 8'hFF, 1'b1, 8'h00, 1'b0, 4'd0,  1'b0};
      tbl[10] = '{1'b1, 4'd0,  8'h00, 8'h00, 1'b0, 8'h5A, 1'b1, 4'd15, 1'b0};

      // Reset state, with write activity that must be ignored while held.
      tick();
      wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h5A; wr_mask = 8'hFF; wr_valid = 1'b1;
      srch_en = 1'b1; srch_key = 8'h5A;
      tick();
      wr_en = 1'b0; srch_en = 1'b0;
      tick();
      check_rslt("reset", 1'b0, 1'b0, 0, 1'b0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         if (tbl[i].is_srch)
            do_search($sformatf("vec%0d", i), tbl[i].key, tbl[i].exp_hit, int'(tbl[i].exp_idx), tbl[i].exp_multi);
         else
            do_write(tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].vld);
      end

      // Entry 0 = x0 (low nibble cares) overlaps entry 3 on key A0: lowest index wins.
      do_write(4'd0, 8'h50, 8'h0F, 1'b1);
      do_search("ovl", 8'hA0, 1'b1, 0, 1'b1);

      // Write and search on the same edge see old contents; next search sees the entry.
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h3C; wr_mask = 8'hFF; wr_valid = 1'b1;
      srch_en = 1'b1; srch_key = 8'h3C;
      tick();
      wr_en = 1'b0;
      tick();
      srch_en = 1'b0;
      check_rslt("wr_same", 1'b1, 1'b0, 0, 1'b0);
      tick();
      check_rslt("wr_next", 1'b1, 1'b1, 5, 1'b0);

      // clr with a write of entry 2; the same-edge search still sees entry 5.
      clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h3C; wr_mask = 8'hFF; wr_valid = 1'b1;
      srch_en = 1'b1; srch_key = 8'h3C;
      tick();
      clr = 1'b0; wr_en = 1'b0; srch_en = 1'b0;
      tick();
      check_rslt("clr_same", 1'b1, 1'b1, 5, 1'b0);
      do_search("clr_e2", 8'h3C, 1'b1, 2, 1'b0);
      do_search("clr_gone", 8'hA0, 1'b0, 0, 1'b0);

      // Four back-to-back searches stream out in order.
      do_write(4'd12, 8'hF0, 8'hF0, 1'b1);
      bb_key[0] = 8'h3C; bb_hit[0] = 1'b1; bb_idx[0] = 2;
      bb_key[1] = 8'hF7; bb_hit[1] = 1'b1; bb_idx[1] = 12;
      bb_key[2] = 8'h00; bb_hit[2] = 1'b0; bb_idx[2] = 0;
      bb_key[3] = 8'hF0; bb_hit[3] = 1'b1; bb_idx[3] = 12;
      for (int i = 0; i < 5; i++) begin
         srch_en  = (i < 4);
         srch_key = (i < 4) ? bb_key[i] : 8'h00;
         tick();
         if (i == 0) check("b2b.lat1", int'(rslt_valid), 0);
         else check_rslt($sformatf("b2b%0d", i - 1), 1'b1, bb_hit[i-1], bb_idx[i-1], 1'b0);
      end
      srch_en = 1'b0;
      tick();
      check("b2b.tail", int'(rslt_valid), 0);

      // Reset one cycle after a search: the in-flight result never appears.
      srch_en = 1'b1; srch_key = 8'h3C;
      tick();
      srch_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_mid.now", int'(rslt_valid), 0);
      tick();
      check("rst_mid.held", int'(rslt_valid), 0);
      rst_n = 1'b1;
      srch_en = 1'b1; srch_key = 8'h3C;
      tick();
      srch_en = 1'b0;
      check("rst_mid.after", int'(rslt_valid), 0);
      tick();
      check_rslt("rst_first", 1'b1, 1'b0, 0, 1'b0);
      do_search("rst_e12", 8'hF7, 1'b0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
